// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory bus between two masters: master 0 is the CPU load/store
//   and fetch port, master 1 is a secondary requester such as DMA or debug.
//   Each master gets a one-entry pending slot. Grants alternate round-robin,
//   and only one transaction is on the bus at a time. The slave's completion
//   is routed back only to the master that owns the bus.
//
//   Optional feature: define MEM_BUS_ARB_TIMEOUT_EN to enable a WAIT timeout.
//   A transaction with no slave answer for TIMEOUT_CYCLES WAIT cycles is
//   aborted. The owner then gets a completion with data 0 and the err flag set.
//   Without the macro, WAIT holds indefinitely and o_m0_err / o_m1_err are 0.
//
//   Ports
//     i_clk, i_reset            clock, synchronous active-high reset
//     i_mX_bus_*, i_mX_bhw,     per-master request strobe and payload
//     i_mX_write_notread
//     o_mX_bus_data/_DV/_err    per-master read data, completion strobe, timeout flag
//     o_bus_*, o_bhw,           slave-side request
//     o_write_notread
//     i_bus_data, i_bus_DV      slave read data and completion strobe
//     o_owner, o_busy           current bus owner (valid while busy), busy flag
//
//   state  | meaning
//   IDLE   | no transaction; grant a pending slot if one is valid
//   ISSUE  | o_bus_DV high for one cycle
//   WAIT   | waiting for the slave completion strobe (or the timeout)

module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_bus_DV,
  input  logic [31:0] i_m0_bus_address,
  input  logic [31:0] i_m0_bus_data,
  input  logic [2:0]  i_m0_bhw,
  input  logic        i_m0_write_notread,
  input  logic        i_m1_bus_DV,
  input  logic [31:0] i_m1_bus_address,
  input  logic [31:0] i_m1_bus_data,
  input  logic [2:0]  i_m1_bhw,
  input  logic        i_m1_write_notread,
  output logic [31:0] o_m0_bus_data,
  output logic        o_m0_bus_DV,
  output logic        o_m0_err,
  output logic [31:0] o_m1_bus_data,
  output logic        o_m1_bus_DV,
  output logic        o_m1_err,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_data,
  output logic [2:0]  o_bhw,
  output logic        o_write_notread,
  output logic        o_bus_DV,
  input  logic [31:0] i_bus_data,
  input  logic        i_bus_DV,
  output logic        o_owner,
  output logic        o_busy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  bhw;
    logic        wnr;
  } req_t;

  state_t      state_q, state_d;
  logic        slot0_vld_q, slot0_vld_d;
  logic        slot1_vld_q, slot1_vld_d;
  req_t        slot0_q, slot0_d;
  req_t        slot1_q, slot1_d;
  req_t        txn_q, txn_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        cmpl0_q, cmpl0_d;
  logic        cmpl1_q, cmpl1_d;
  logic        grant1;
  logic        act0, act1;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;
`endif

  // A master owning an in-flight transaction may not queue another request.
  assign act0 = (state_q != ST_IDLE) && (owner_q == 1'b0);
  assign act1 = (state_q != ST_IDLE) && (owner_q == 1'b1);

  always_comb begin
    state_d     = state_q;
    slot0_vld_d = slot0_vld_q;
    slot1_vld_d = slot1_vld_q;
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    txn_d       = txn_q;
    owner_d     = owner_q;
    last_d      = last_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    cmpl0_d     = 1'b0;
    cmpl1_d     = 1'b0;
    grant1      = 1'b0;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
`endif

    // A slot can only load while empty, and a grant only clears a full slot,
    // so the two updates below never collide.
    if (i_m0_bus_DV && !slot0_vld_q && !act0) begin
      slot0_vld_d = 1'b1;
      slot0_d     = '{addr: i_m0_bus_address, data: i_m0_bus_data,
                      bhw: i_m0_bhw, wnr: i_m0_write_notread};
    end
    if (i_m1_bus_DV && !slot1_vld_q && !act1) begin
      slot1_vld_d = 1'b1;
      slot1_d     = '{addr: i_m1_bus_address, data: i_m1_bus_data,
                      bhw: i_m1_bhw, wnr: i_m1_write_notread};
    end

    case (state_q)
      ST_IDLE: begin
        // Hold off the grant during a completion-strobe cycle. This keeps
        // at least two cycles between a completion and the next issue.
        if (!cmpl0_q && !cmpl1_q && (slot0_vld_q || slot1_vld_q)) begin
          grant1  = slot1_vld_q && (!slot0_vld_q || !last_q);
          owner_d = grant1;
          last_d  = grant1;
          if (grant1) begin
            txn_d       = slot1_q;
            slot1_vld_d = 1'b0;
          end else begin
            txn_d       = slot0_q;
            slot0_vld_d = 1'b0;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
`ifdef MEM_BUS_ARB_TIMEOUT_EN
        wait_cnt_d = 16'd0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
`ifdef MEM_BUS_ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + 16'd1;
`endif
        if (i_bus_DV) begin
          if (owner_q) begin
            rdata1_d = i_bus_data;
            cmpl1_d  = 1'b1;
          end else begin
            rdata0_d = i_bus_data;
            cmpl0_d  = 1'b1;
          end
          state_d = ST_IDLE;
        end
`ifdef MEM_BUS_ARB_TIMEOUT_EN
        else if (wait_cnt_q == TO_LAST) begin
          if (owner_q) begin
            rdata1_d = 32'h0;
            cmpl1_d  = 1'b1;
            err1_d   = 1'b1;
          end else begin
            rdata0_d = 32'h0;
            cmpl0_d  = 1'b1;
            err0_d   = 1'b1;
          end
          state_d = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      slot0_vld_q <= 1'b0;
      slot1_vld_q <= 1'b0;
      slot0_q     <= '0;
      slot1_q     <= '0;
      txn_q       <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      rdata0_q    <= 32'h0;
      rdata1_q    <= 32'h0;
      cmpl0_q     <= 1'b0;
      cmpl1_q     <= 1'b0;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
      wait_cnt_q  <= 16'd0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      slot0_vld_q <= slot0_vld_d;
      slot1_vld_q <= slot1_vld_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      txn_q       <= txn_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      cmpl0_q     <= cmpl0_d;
      cmpl1_q     <= cmpl1_d;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
`endif
    end
  end

  assign o_bus_address   = txn_q.addr;
  assign o_bus_data      = txn_q.data;
  assign o_bhw           = txn_q.bhw;
  assign o_write_notread = txn_q.wnr;
  assign o_bus_DV        = (state_q == ST_ISSUE);
  assign o_busy          = (state_q != ST_IDLE);
  assign o_owner         = owner_q;
  assign o_m0_bus_data   = rdata0_q;
  assign o_m1_bus_data   = rdata1_q;
  assign o_m0_bus_DV     = cmpl0_q;
  assign o_m1_bus_DV     = cmpl1_q;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
  assign o_m0_err        = err0_q;
  assign o_m1_err        = err1_q;
`else
  assign o_m0_err        = 1'b0;
  assign o_m1_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Built with TIMEOUT_CYCLES=4; the timeout
// section is compiled only when MEM_BUS_ARB_TIMEOUT_EN is defined.

module tb_mem_bus_arbiter;

  logic        i_clk;
  logic        i_reset;
  logic        i_m0_bus_DV, i_m1_bus_DV;
  logic [31:0] i_m0_bus_address, i_m1_bus_address;
  logic [31:0] i_m0_bus_data, i_m1_bus_data;
  logic [2:0]  i_m0_bhw, i_m1_bhw;
  logic        i_m0_write_notread, i_m1_write_notread;
  logic [31:0] o_m0_bus_data, o_m1_bus_data;
  logic        o_m0_bus_DV, o_m1_bus_DV;
  logic        o_m0_err, o_m1_err;
  logic [31:0] o_bus_address, o_bus_data;
  logic [2:0]  o_bhw;
  logic        o_write_notread;
  logic        o_bus_DV;
  logic [31:0] i_bus_data;
  logic        i_bus_DV;
  logic        o_owner;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  int n;
  int cnt_bus, cnt_m0, cnt_m1;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .i_m0_bus_DV        (i_m0_bus_DV),
    .i_m0_bus_address   (i_m0_bus_address),
    .i_m0_bus_data      (i_m0_bus_data),
    .i_m0_bhw           (i_m0_bhw),
    .i_m0_write_notread (i_m0_write_notread),
    .i_m1_bus_DV        (i_m1_bus_DV),
    .i_m1_bus_address   (i_m1_bus_address),
    .i_m1_bus_data      (i_m1_bus_data),
    .i_m1_bhw           (i_m1_bhw),
    .i_m1_write_notread (i_m1_write_notread),
    .o_m0_bus_data      (o_m0_bus_data),
    .o_m0_bus_DV        (o_m0_bus_DV),
    .o_m0_err           (o_m0_err),
    .o_m1_bus_data      (o_m1_bus_data),
    .o_m1_bus_DV        (o_m1_bus_DV),
    .o_m1_err           (o_m1_err),
    .o_bus_address      (o_bus_address),
    .o_bus_data         (o_bus_data),
    .o_bhw              (o_bhw),
    .o_write_notread    (o_write_notread),
    .o_bus_DV           (o_bus_DV),
    .i_bus_data         (i_bus_data),
    .i_bus_DV           (i_bus_DV),
    .o_owner            (o_owner),
    .o_busy             (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic req(input bit m, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] b, input logic w);
    if (!m) begin
      i_m0_bus_DV = 1'b1; i_m0_bus_address = a; i_m0_bus_data = d;
      i_m0_bhw = b; i_m0_write_notread = w;
    end else begin
      i_m1_bus_DV = 1'b1; i_m1_bus_address = a; i_m1_bus_data = d;
      i_m1_bhw = b; i_m1_write_notread = w;
    end
  endtask

  task automatic clr_req();
    i_m0_bus_DV = 1'b0;
    i_m1_bus_DV = 1'b0;
  endtask

  // Advance until o_bus_DV is seen (bounded); n = cycles advanced.
  task automatic wait_issue(input string tag, input logic exp_owner,
                            input logic [31:0] exp_addr, output int cycles);
    cycles = 0;
    while (!o_bus_DV && cycles < 8) begin
      cyc();
      cycles++;
    end
    check({tag, "_issue"}, o_bus_DV, 1);
    check({tag, "_owner"}, o_owner, exp_owner);
    check({tag, "_addr"}, o_bus_address, exp_addr);
  endtask

  // Wait k cycles, then pulse the slave strobe; ends in the completion cycle.
  task automatic respond(input int k, input logic [31:0] d);
    repeat (k) cyc();
    i_bus_DV = 1'b1;
    i_bus_data = d;
    cyc();
    i_bus_DV = 1'b0;
    i_bus_data = 32'h0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1;
    i_m0_bus_DV = 0; i_m0_bus_address = 0; i_m0_bus_data = 0; i_m0_bhw = 0; i_m0_write_notread = 0;
    i_m1_bus_DV = 0; i_m1_bus_address = 0; i_m1_bus_data = 0; i_m1_bhw = 0; i_m1_write_notread = 0;
    i_bus_DV = 0; i_bus_data = 0;
    cyc(); cyc();

    // strobe in the same cycle as reset is discarded
    req(0, 32'h0000_0055, 32'h0, 3'b100, 1'b0);
    cyc();
    i_reset = 1'b0;
    clr_req();
    check("rst_busy", o_busy, 0);
    check("rst_bus_dv", o_bus_DV, 0);
    check("rst_m0_dv", o_m0_bus_DV, 0);
    check("rst_m1_dv", o_m1_bus_DV, 0);
    check("rst_addr", o_bus_address, 32'h0);
    check("rst_owner", o_owner, 0);
    cyc(); cyc();
    check("rst_discard_dv", o_bus_DV, 0);
    check("rst_discard_busy", o_busy, 0);

    // m0 read, slave answers k=3
    req(0, 32'h0000_0100, 32'h0, 3'b100, 1'b0);
    cyc();
    clr_req();
    check("a_t1_dv", o_bus_DV, 0);
    cyc();
    check("a_t2_dv", o_bus_DV, 1);
    check("a_t2_addr", o_bus_address, 32'h0000_0100);
    check("a_t2_wnr", o_write_notread, 0);
    respond(3, 32'hCAFE_0001);
    check("a_m0_dv", o_m0_bus_DV, 1);
    check("a_m0_data", o_m0_bus_data, 32'hCAFE_0001);
    check("a_m0_err", o_m0_err, 0);
    check("a_m1_dv", o_m1_bus_DV, 0);
    check("a_busy", o_busy, 0);
    cyc();
    check("a_m0_dv_pulse", o_m0_bus_DV, 0);
    check("a_m0_data_hold", o_m0_bus_data, 32'hCAFE_0001);

    // first tie after reset: m0 then m1
    do_reset();
    req(0, 32'h0000_00A0, 32'h0, 3'b100, 1'b0);
    req(1, 32'h0000_00B0, 32'h0, 3'b100, 1'b0);
    cyc();
    clr_req();
    wait_issue("t1a", 0, 32'h0000_00A0, n);
    respond(1, 32'h0000_0011);
    check("t1a_m0_dv", o_m0_bus_DV, 1);
    check("t1a_m0_data", o_m0_bus_data, 32'h0000_0011);
    check("t1a_m1_dv", o_m1_bus_DV, 0);
    wait_issue("t1b", 1, 32'h0000_00B0, n);
    check("t1b_gap", n >= 2, 1);
    respond(1, 32'h0000_0022);
    check("t1b_m1_dv", o_m1_bus_DV, 1);
    check("t1b_m1_data", o_m1_bus_data, 32'h0000_0022);
    check("t1b_m0_dv", o_m0_bus_DV, 0);
    check("t1b_m0_data_keep", o_m0_bus_data, 32'h0000_0011);

    // m0 solo; repeat strobe in WAIT ignored; spurious slave strobe in IDLE
    req(0, 32'h0000_0300, 32'h0, 3'b100, 1'b0);
    cyc();
    clr_req();
    wait_issue("d", 0, 32'h0000_0300, n);
    cyc();
    req(0, 32'h0000_0400, 32'h0, 3'b100, 1'b0);
    cyc();
    clr_req();
    respond(0, 32'h0000_0033);
    check("d_m0_dv", o_m0_bus_DV, 1);
    check("d_m0_data", o_m0_bus_data, 32'h0000_0033);
    cnt_bus = 0; cnt_m0 = 0; cnt_m1 = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        i_bus_DV = 1'b1;
        i_bus_data = 32'hDEAD_BEEF;
      end
      cyc();
      i_bus_DV = 1'b0;
      i_bus_data = 32'h0;
      cnt_bus += int'(o_bus_DV);
      cnt_m0  += int'(o_m0_bus_DV);
      cnt_m1  += int'(o_m1_bus_DV);
    end
    check("d_no_reissue", cnt_bus, 0);
    check("d_no_m0_dv", cnt_m0, 0);
    check("d_no_m1_dv", cnt_m1, 0);
    check("d_m0_data_keep", o_m0_bus_data, 32'h0000_0033);

    // second tie: m0 granted last, so m1 wins
    req(0, 32'h0000_0500, 32'h0, 3'b100, 1'b0);
    req(1, 32'h0000_0600, 32'h0, 3'b100, 1'b0);
    cyc();
    clr_req();
    wait_issue("t2a", 1, 32'h0000_0600, n);
    respond(1, 32'h0000_0066);
    check("t2a_m1_dv", o_m1_bus_DV, 1);
    check("t2a_m1_data", o_m1_bus_data, 32'h0000_0066);
    check("t2a_m0_dv", o_m0_bus_DV, 0);
    wait_issue("t2b", 0, 32'h0000_0500, n);
    respond(2, 32'h0000_0055);
    check("t2b_m0_dv", o_m0_bus_DV, 1);
    check("t2b_m0_data", o_m0_bus_data, 32'h0000_0055);
    check("t2b_m1_data_keep", o_m1_bus_data, 32'h0000_0066);

    // m1 write; slave strobe during ISSUE is ignored
    req(1, 32'h2000_0000, 32'h1234_5678, 3'b010, 1'b1);
    cyc();
    clr_req();
    wait_issue("c", 1, 32'h2000_0000, n);
    check("c_data", o_bus_data, 32'h1234_5678);
    check("c_bhw", o_bhw, 3'b010);
    check("c_wnr", o_write_notread, 1);
    i_bus_DV = 1'b1;
    i_bus_data = 32'h0000_BAD0;
    cyc();
    i_bus_DV = 1'b0;
    i_bus_data = 32'h0;
    check("c_issue_dv_ignored", o_m1_bus_DV, 0);
    check("c_wait_busy", o_busy, 1);
    check("c_wait_bus_dv", o_bus_DV, 0);
    cyc();
    check("c_hold_addr", o_bus_address, 32'h2000_0000);
    check("c_hold_data", o_bus_data, 32'h1234_5678);
    check("c_hold_bhw", o_bhw, 3'b010);
    check("c_hold_wnr", o_write_notread, 1);
    respond(1, 32'h0000_ABCD);
    check("c_m1_dv", o_m1_bus_DV, 1);
    check("c_m1_data", o_m1_bus_data, 32'h0000_ABCD);
    check("c_m0_dv", o_m0_bus_DV, 0);
    check("c_m0_data_keep", o_m0_bus_data, 32'h0000_0055);
    check("c_addr_after", o_bus_address, 32'h2000_0000);

    // reset in the middle of WAIT
    req(0, 32'h0000_0700, 32'h0000_0077, 3'b001, 1'b1);
    cyc();
    clr_req();
    wait_issue("r", 0, 32'h0000_0700, n);
    cyc(); cyc();
    do_reset();
    check("r_busy", o_busy, 0);
    check("r_addr", o_bus_address, 32'h0);
    check("r_data", o_bus_data, 32'h0);
    check("r_bhw", o_bhw, 3'b000);
    check("r_wnr", o_write_notread, 0);
    check("r_m0_data", o_m0_bus_data, 32'h0);
    check("r_m1_data", o_m1_bus_data, 32'h0);
    check("r_m0_dv", o_m0_bus_DV, 0);
    i_bus_DV = 1'b1;
    i_bus_data = 32'h0000_0BAD;
    cyc();
    i_bus_DV = 1'b0;
    i_bus_data = 32'h0;
    check("r_late_m0_dv", o_m0_bus_DV, 0);
    check("r_late_data", o_m0_bus_data, 32'h0);
    cyc();
    check("r_late_m0_dv2", o_m0_bus_DV, 0);
    check("r_late_bus_dv", o_bus_DV, 0);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    // slave answers on the 4th WAIT cycle: wins over the limit
    req(0, 32'h0000_0900, 32'h0, 3'b100, 1'b0);
    cyc();
    clr_req();
    wait_issue("to_ok", 0, 32'h0000_0900, n);
    respond(4, 32'h0000_0044);
    check("to_ok_dv", o_m0_bus_DV, 1);
    check("to_ok_err", o_m0_err, 0);
    check("to_ok_data", o_m0_bus_data, 32'h0000_0044);

    // silent slave: abort after 4 WAIT cycles, completion 5 cycles after ISSUE
    req(0, 32'h0000_0A00, 32'h0, 3'b100, 1'b0);
    cyc();
    clr_req();
    wait_issue("to_ab", 0, 32'h0000_0A00, n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!o_m0_bus_DV && n < 12);
    check("to_ab_latency", n, 5);
    check("to_ab_dv", o_m0_bus_DV, 1);
    check("to_ab_err", o_m0_err, 1);
    check("to_ab_data", o_m0_bus_data, 32'h0);
    check("to_ab_m1_err", o_m1_err, 0);
    check("to_ab_busy", o_busy, 0);
    cyc();
    check("to_ab_err_pulse", o_m0_err, 0);
    check("to_ab_dv_pulse", o_m0_bus_DV, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
